// File: rtl/ocp_slave_fsm_pkg.sv
// Shared OCP widths/encodings (same values the OCP master uses) and slave FSM types.
`ifndef OCP_CONST_VH
`define OCP_CONST_VH
`define MADDR_WIDTH   8
`define MDATA_WIDTH   16
`define SDATA_WIDTH   `MDATA_WIDTH
`define OCP_CMD_IDLE  3'b000
`define OCP_CMD_WR    3'b001
`define OCP_CMD_RD    3'b010
`define OCP_RESP_NULL 2'b00
`define OCP_RESP_DVA  2'b01
`define OCP_RESP_FAIL 2'b10
`define OCP_RESP_ERR  2'b11
`endif

package ocp_slave_fsm_pkg;

  localparam int unsigned MADDR_W = `MADDR_WIDTH;
  localparam int unsigned MDATA_W = `MDATA_WIDTH;
  localparam int unsigned CNT_W   = 3;

  localparam logic [2:0] CMD_WR = `OCP_CMD_WR;
  localparam logic [2:0] CMD_RD = `OCP_CMD_RD;

  // FAIL (2'b10) is reserved and never produced by this slave
  localparam logic [1:0] RESP_NULL = `OCP_RESP_NULL;
  localparam logic [1:0] RESP_DVA  = `OCP_RESP_DVA;
  localparam logic [1:0] RESP_ERR  = `OCP_RESP_ERR;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RWAIT = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

endpackage

// File: rtl/ocp_slave_mem.sv
// Word storage: one synchronous write port, one asynchronous read port, async clear.
module ocp_slave_mem #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage array; reset clears every word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/ocp_slave_fsm.sv
// OCP slave: posted writes, fixed-latency reads with DVA/ERR response, clock-enable aware.
module ocp_slave_fsm
  import ocp_slave_fsm_pkg::*;
#(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic                     Clk,
  input  logic                     reset,
  input  logic                     EnableClk,
  input  logic [`MADDR_WIDTH-1:0]  MAddr,
  input  logic [2:0]               MCmd,
  input  logic [`MDATA_WIDTH-1:0]  MData,
  input  logic                     MDataValid,
  output logic                     SCmdAccept,
  output logic                     SDataAccept,
  output logic [`SDATA_WIDTH-1:0]  SData,
  output logic [1:0]               SResp,
  output logic                     wr_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned AW1   = MADDR_W + 1;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rd_err_q, rd_err_d;
  logic [MDATA_W-1:0]  rd_data_q, rd_data_d;
  logic [1:0]          sresp_q, sresp_d;
  logic [MDATA_W-1:0]  sdata_q, sdata_d;
  logic                wr_err_q, wr_err_d;

  logic                is_wr_c, is_rd_c, cmd_acc_c, addr_ok_c, mem_we_c;
  logic [MDATA_W-1:0]  mem_rdata_c;

  // Command decode and accept handshake (combinational by interface definition)
  always_comb begin
    is_wr_c   = (MCmd == CMD_WR);
    is_rd_c   = (MCmd == CMD_RD);
    cmd_acc_c = EnableClk & (state_q == ST_IDLE) & (is_rd_c | (is_wr_c & MDataValid));
    addr_ok_c = ({1'b0, MAddr} < AW1'(DEPTH));
    mem_we_c  = cmd_acc_c & is_wr_c & addr_ok_c;
  end

  assign SCmdAccept  = cmd_acc_c;
  assign SDataAccept = cmd_acc_c & is_wr_c;

  ocp_slave_mem #(
    .DEPTH (DEPTH),
    .WIDTH (MDATA_W)
  ) u_mem (
    .clk   (Clk),
    .rst_n (reset),
    .we    (mem_we_c),
    .waddr (MAddr[IDX_W-1:0]),
    .wdata (MData),
    .raddr (MAddr[IDX_W-1:0]),
    .rdata (mem_rdata_c)
  );

  // Next-state, latency counter and response/error register inputs
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_err_d  = rd_err_q;
    rd_data_d = rd_data_q;
    sresp_d   = sresp_q;
    sdata_d   = sdata_q;
    wr_err_d  = wr_err_q;
    if (EnableClk) begin
      wr_err_d = cmd_acc_c & is_wr_c & ~addr_ok_c;
      case (state_q)
        ST_IDLE: begin
          if (cmd_acc_c && is_rd_c) begin
            // read data is snapshotted at the accept edge
            rd_err_d  = ~addr_ok_c;
            rd_data_d = addr_ok_c ? mem_rdata_c : '0;
            cnt_d     = CNT_W'(RD_LATENCY - 1);
            state_d   = (RD_LATENCY == 1) ? ST_RESP : ST_RWAIT;
          end
        end
        ST_RWAIT: begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q <= CNT_W'(1)) begin
            state_d = ST_RESP;
          end
        end
        ST_RESP: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
      sresp_d = RESP_NULL;
      sdata_d = '0;
      if (state_d == ST_RESP) begin
        sresp_d = rd_err_d ? RESP_ERR : RESP_DVA;
        sdata_d = rd_data_d;
      end
    end
  end

  // State and output registers; everything holds while EnableClk is low
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rd_err_q  <= 1'b0;
      rd_data_q <= '0;
      sresp_q   <= RESP_NULL;
      sdata_q   <= '0;
      wr_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_err_q  <= rd_err_d;
      rd_data_q <= rd_data_d;
      sresp_q   <= sresp_d;
      sdata_q   <= sdata_d;
      wr_err_q  <= wr_err_d;
    end
  end

  assign SResp  = sresp_q;
  assign SData  = sdata_q;
  assign wr_err = wr_err_q;

endmodule

// File: tb/tb_ocp_slave_fsm.sv
// Bench for ocp_slave_fsm: directed scenarios plus randomized traffic against a transaction model.
module tb_ocp_slave_fsm;
  import ocp_slave_fsm_pkg::*;

  localparam int DEPTH = 16;
  localparam int LAT   = 2;

  logic               Clk;
  logic               reset;
  logic               EnableClk;
  logic [MADDR_W-1:0] MAddr;
  logic [2:0]         MCmd;
  logic [MDATA_W-1:0] MData;
  logic               MDataValid;
  logic               SCmdAccept;
  logic               SDataAccept;
  logic [MDATA_W-1:0] SData;
  logic [1:0]         SResp;
  logic               wr_err;

  int total;
  int bad;

  ocp_slave_fsm #(
    .DEPTH      (DEPTH),
    .RD_LATENCY (LAT)
  ) dut (
    .Clk         (Clk),
    .reset       (reset),
    .EnableClk   (EnableClk),
    .MAddr       (MAddr),
    .MCmd        (MCmd),
    .MData       (MData),
    .MDataValid  (MDataValid),
    .SCmdAccept  (SCmdAccept),
    .SDataAccept (SDataAccept),
    .SData       (SData),
    .SResp       (SResp),
    .wr_err      (wr_err)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic drive(input logic en, input logic [2:0] cmd, input logic [MADDR_W-1:0] a,
                       input logic [MDATA_W-1:0] d, input logic dv);
    EnableClk  = en;
    MCmd       = cmd;
    MAddr      = a;
    MData      = d;
    MDataValid = dv;
    #1;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Full read from IDLE; returns what the slave presented in the response cycle
  task automatic do_read(input logic [MADDR_W-1:0] a, output logic [1:0] r, output logic [MDATA_W-1:0] d);
    drive(1'b1, CMD_RD, a, '0, 1'b0);
    tick();
    drive(1'b1, 3'b000, '0, '0, 1'b0);
    repeat (LAT - 1) tick();
    r = SResp;
    d = SData;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1'b1, 3'b000, '0, '0, 1'b0);
    repeat (2) tick();
    if (SResp !== 2'b00) begin bad++; $display("FAIL reset.sresp: got %b want 00", SResp); end
    total++;
    if (SData !== '0) begin bad++; $display("FAIL reset.sdata: got %h want 0", SData); end
    total++;
    if (wr_err !== 1'b0) begin bad++; $display("FAIL reset.wr_err: got %b want 0", wr_err); end
    total++;
    reset = 1'b1;
  endtask

  task automatic test_write_read();
    drive(1'b1, CMD_WR, 8'd3, 16'h00A5, 1'b1);
    if (SCmdAccept !== 1'b1) begin bad++; $display("FAIL wr_rd.wr_accept: got %b want 1", SCmdAccept); end
    total++;
    if (SDataAccept !== 1'b1) begin bad++; $display("FAIL wr_rd.data_accept: got %b want 1", SDataAccept); end
    total++;
    tick();
    if (SResp !== 2'b00) begin bad++; $display("FAIL wr_rd.posted: got %b want 00", SResp); end
    total++;
    drive(1'b1, CMD_RD, 8'd3, '0, 1'b0);
    if (SCmdAccept !== 1'b1) begin bad++; $display("FAIL wr_rd.rd_accept: got %b want 1", SCmdAccept); end
    total++;
    if (SDataAccept !== 1'b0) begin bad++; $display("FAIL wr_rd.rd_data_accept: got %b want 0", SDataAccept); end
    total++;
    tick();
    drive(1'b1, 3'b000, '0, '0, 1'b0);
    if (SResp !== 2'b00) begin bad++; $display("FAIL wr_rd.early_resp: got %b want 00", SResp); end
    total++;
    tick();
    if (SResp !== 2'b01 || SData !== 16'h00A5) begin
      bad++; $display("FAIL wr_rd.resp: got %b/%h want 01/00a5", SResp, SData);
    end
    total++;
    tick();
    if (SResp !== 2'b00 || SData !== '0) begin
      bad++; $display("FAIL wr_rd.resp_end: got %b/%h want 00/0000", SResp, SData);
    end
    total++;
  endtask

  task automatic test_data_handshake();
    logic [1:0] r;
    logic [MDATA_W-1:0] d;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, CMD_WR, 8'd1, 16'h5A5A, 1'b0);
      if (SCmdAccept !== 1'b0 || SDataAccept !== 1'b0) begin
        bad++; $display("FAIL hs.pending%0d: got %b%b want 00", i, SCmdAccept, SDataAccept);
      end
      total++;
      tick();
    end
    do_read(8'd1, r, d);
    if (r !== 2'b01 || d !== '0) begin bad++; $display("FAIL hs.word_unchanged: got %b/%h want 01/0000", r, d); end
    total++;
    drive(1'b1, CMD_WR, 8'd1, 16'h5A5A, 1'b1);
    if (SCmdAccept !== 1'b1 || SDataAccept !== 1'b1) begin
      bad++; $display("FAIL hs.accept: got %b%b want 11", SCmdAccept, SDataAccept);
    end
    total++;
    tick();
    do_read(8'd1, r, d);
    if (r !== 2'b01 || d !== 16'h5A5A) begin bad++; $display("FAIL hs.word_written: got %b/%h want 01/5a5a", r, d); end
    total++;
  endtask

  task automatic test_out_of_range();
    logic [1:0] r;
    logic [MDATA_W-1:0] d;
    drive(1'b1, CMD_WR, 8'(DEPTH), 16'hFFFF, 1'b1);
    if (SCmdAccept !== 1'b1) begin bad++; $display("FAIL oor.wr_accept: got %b want 1", SCmdAccept); end
    total++;
    tick();
    drive(1'b1, 3'b000, '0, '0, 1'b0);
    if (wr_err !== 1'b1) begin bad++; $display("FAIL oor.wr_err_pulse: got %b want 1", wr_err); end
    total++;
    if (SResp !== 2'b00) begin bad++; $display("FAIL oor.wr_posted: got %b want 00", SResp); end
    total++;
    tick();
    if (wr_err !== 1'b0) begin bad++; $display("FAIL oor.wr_err_end: got %b want 0", wr_err); end
    total++;
    do_read(8'd0, r, d);
    if (r !== 2'b01 || d !== '0) begin bad++; $display("FAIL oor.alias_word: got %b/%h want 01/0000", r, d); end
    total++;
    do_read(8'(DEPTH + 5), r, d);
    if (r !== 2'b11 || d !== '0) begin bad++; $display("FAIL oor.rd_err: got %b/%h want 11/0000", r, d); end
    total++;
  endtask

  task automatic test_back_to_back();
    drive(1'b1, CMD_WR, 8'd5, 16'h1234, 1'b1);
    tick();
    drive(1'b1, CMD_WR, 8'd6, 16'h0BEE, 1'b1);
    tick();
    drive(1'b1, CMD_RD, 8'd5, '0, 1'b0);
    if (SCmdAccept !== 1'b1) begin bad++; $display("FAIL b2b.first_accept: got %b want 1", SCmdAccept); end
    total++;
    tick();
    drive(1'b1, CMD_RD, 8'd6, '0, 1'b0);
    if (SCmdAccept !== 1'b0) begin bad++; $display("FAIL b2b.rwait_block: got %b want 0", SCmdAccept); end
    total++;
    tick();
    if (SCmdAccept !== 1'b0) begin bad++; $display("FAIL b2b.resp_block: got %b want 0", SCmdAccept); end
    total++;
    if (SResp !== 2'b01 || SData !== 16'h1234) begin
      bad++; $display("FAIL b2b.first_resp: got %b/%h want 01/1234", SResp, SData);
    end
    total++;
    tick();
    if (SCmdAccept !== 1'b1) begin bad++; $display("FAIL b2b.second_accept: got %b want 1", SCmdAccept); end
    total++;
    tick();
    drive(1'b1, 3'b000, '0, '0, 1'b0);
    tick();
    if (SResp !== 2'b01 || SData !== 16'h0BEE) begin
      bad++; $display("FAIL b2b.second_resp: got %b/%h want 01/0bee", SResp, SData);
    end
    total++;
    tick();
  endtask

  task automatic test_clock_enable();
    drive(1'b1, CMD_RD, 8'd5, '0, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, CMD_RD, 8'd5, '0, 1'b0);
      if (SCmdAccept !== 1'b0 || SResp !== 2'b00) begin
        bad++; $display("FAIL ce.hold%0d: got acc=%b resp=%b want acc=0 resp=00", i, SCmdAccept, SResp);
      end
      total++;
      tick();
    end
    drive(1'b1, 3'b000, '0, '0, 1'b0);
    if (SResp !== 2'b00) begin bad++; $display("FAIL ce.no_early: got %b want 00", SResp); end
    total++;
    tick();
    if (SResp !== 2'b01 || SData !== 16'h1234) begin
      bad++; $display("FAIL ce.delayed_resp: got %b/%h want 01/1234", SResp, SData);
    end
    total++;
    drive(1'b0, 3'b000, '0, '0, 1'b0);
    tick();
    if (SResp !== 2'b01) begin bad++; $display("FAIL ce.resp_hold: got %b want 01", SResp); end
    total++;
    drive(1'b1, 3'b000, '0, '0, 1'b0);
    tick();
  endtask

  task automatic test_reset_mid_read();
    logic [1:0] r;
    logic [MDATA_W-1:0] d;
    drive(1'b1, CMD_WR, 8'd7, 16'h0077, 1'b1);
    tick();
    drive(1'b1, CMD_RD, 8'd7, '0, 1'b0);
    tick();
    drive(1'b1, 3'b000, '0, '0, 1'b0);
    reset = 1'b0;
    #1;
    if (SResp !== 2'b00) begin bad++; $display("FAIL rstmid.async: got %b want 00", SResp); end
    total++;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (SResp !== 2'b00) begin bad++; $display("FAIL rstmid.no_resp%0d: got %b want 00", i, SResp); end
      total++;
    end
    drive(1'b1, 3'b100, 8'd7, '0, 1'b1);
    if (SCmdAccept !== 1'b0) begin bad++; $display("FAIL rstmid.cmd100: got %b want 0", SCmdAccept); end
    total++;
    tick();
    if (SResp !== 2'b00) begin bad++; $display("FAIL rstmid.cmd100_resp: got %b want 00", SResp); end
    total++;
    do_read(8'd7, r, d);
    if (r !== 2'b01 || d !== '0) begin bad++; $display("FAIL rstmid.cleared: got %b/%h want 01/0000", r, d); end
    total++;
  endtask

  // Transaction-level model: progress is counted in enabled edges; a read accepted
  // at edge a answers at edge a+LAT-1 and frees the slave at edge a+LAT.
  task automatic test_random();
    logic [MDATA_W-1:0] mdl [DEPTH];
    int n, free_n, rsp_n, werr_n;
    logic [1:0] rsp_code;
    logic [MDATA_W-1:0] rsp_data;
    logic en, dv, exp_acc, exp_werr;
    logic [2:0] cmd;
    logic [MADDR_W-1:0] a;
    logic [MDATA_W-1:0] d;
    logic [1:0] exp_resp;
    logic [MDATA_W-1:0] exp_data;
    int sel;
    reset = 1'b0;
    drive(1'b1, 3'b000, '0, '0, 1'b0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    n = 0; free_n = 0; rsp_n = -1; werr_n = -1;
    rsp_code = 2'b00; rsp_data = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      en  = ($urandom_range(0, 7) != 0);
      dv  = ($urandom_range(0, 9) < 7);
      sel = $urandom_range(0, 9);
      if (sel < 4)      cmd = CMD_WR;
      else if (sel < 7) cmd = CMD_RD;
      else if (sel < 8) cmd = 3'b000;
      else              cmd = 3'($urandom_range(3, 7));
      if ($urandom_range(0, 7) == 0) a = 8'($urandom_range(0, 255));
      else                           a = 8'($urandom_range(0, DEPTH + 3));
      d = 16'($urandom);
      drive(en, cmd, a, d, dv);
      exp_acc = en && (n >= free_n) && ((cmd == CMD_WR && dv) || cmd == CMD_RD);
      if (SCmdAccept !== exp_acc) begin
        bad++; $display("FAIL rnd.accept c%0d: got %b want %b", cyc, SCmdAccept, exp_acc);
      end
      total++;
      if (SDataAccept !== (exp_acc && cmd == CMD_WR)) begin
        bad++; $display("FAIL rnd.data_accept c%0d: got %b want %b", cyc, SDataAccept, exp_acc && cmd == CMD_WR);
      end
      total++;
      if (en) begin
        n++;
        if (exp_acc && cmd == CMD_WR) begin
          if (int'(a) < DEPTH) mdl[int'(a)] = d;
          else                 werr_n = n;
        end else if (exp_acc) begin
          rsp_n  = n + LAT - 1;
          free_n = n + LAT;
          if (int'(a) < DEPTH) begin rsp_code = 2'b01; rsp_data = mdl[int'(a)]; end
          else                 begin rsp_code = 2'b11; rsp_data = '0; end
        end
      end
      tick();
      exp_resp = (n == rsp_n) ? rsp_code : 2'b00;
      exp_data = (n == rsp_n) ? rsp_data : '0;
      exp_werr = (n == werr_n);
      if (SResp !== exp_resp || SData !== exp_data) begin
        bad++; $display("FAIL rnd.resp c%0d: got %b/%h want %b/%h", cyc, SResp, SData, exp_resp, exp_data);
      end
      total++;
      if (wr_err !== exp_werr) begin
        bad++; $display("FAIL rnd.wr_err c%0d: got %b want %b", cyc, wr_err, exp_werr);
      end
      total++;
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    EnableClk = 1'b0; MCmd = 3'b000; MAddr = '0; MData = '0; MDataValid = 1'b0;
    test_reset();
    test_write_read();
    test_data_handshake();
    test_out_of_range();
    test_back_to_back();
    test_clock_enable();
    test_reset_mid_read();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ocp_slave_fsm.md
OCP_SLAVE_FSM -- requirements
Module: ocp_slave_fsm

Interface
REQ-001 SHALL have parameter DEPTH, default 16: number of storage words; legal values are powers of two, 2..256.
REQ-002 SHALL have parameter RD_LATENCY, default 2: cycles from read accept to response; legal range 1..7.
REQ-003 SHALL have port Clk, input, 1 bit: single clock; all state changes on rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port EnableClk, input, 1 bit: OCP clock enable; qualifies every state update.
REQ-006 SHALL have port MAddr, input, `MADDR_WIDTH bits: word address.
REQ-007 SHALL have port MCmd, input, 3 bits: 000 IDLE, 001 WR, 010 RD; all other codes are treated as IDLE.
REQ-008 SHALL have port MData, input, `MDATA_WIDTH bits: write data.
REQ-009 SHALL have port MDataValid, input, 1 bit: MData qualifier.
REQ-010 SHALL have port SCmdAccept, output, 1 bit: command accepted this cycle.
REQ-011 SHALL have port SDataAccept, output, 1 bit: write data accepted this cycle.
REQ-012 SHALL have port SData, output, `SDATA_WIDTH bits: read data; `SDATA_WIDTH equals `MDATA_WIDTH.
REQ-013 SHALL have port SResp, output, 2 bits: 00 NULL, 01 DVA, 10 FAIL, 11 ERR.
REQ-014 SHALL have port wr_err, output, 1 bit: one-cycle pulse on an out-of-range write.

Function
REQ-015 SHALL implement states IDLE, RWAIT and RESP, with IDLE as the only state that accepts commands.
REQ-016 SHALL drive SCmdAccept combinationally as EnableClk & IDLE & (MCmd==RD | (MCmd==WR & MDataValid)).
REQ-017 SHALL drive SDataAccept equal to SCmdAccept whenever MCmd==WR, and 0 otherwise.
REQ-018 SHALL leave an unaccepted WR (MDataValid=0) pending, with no state change and no storage change.
REQ-019 SHALL, on an accepted WR with MAddr<DEPTH, write MData to word MAddr[log2(DEPTH)-1:0] at that edge and remain in IDLE.
REQ-020 SHALL treat writes as posted: SResp stays NULL for every write.
REQ-021 SHALL, on an accepted WR with MAddr>=DEPTH, leave storage unchanged and pulse wr_err for the next cycle.
REQ-022 SHALL, on an accepted RD, capture address and range check, load a down-counter with RD_LATENCY-1, and go to RESP if RD_LATENCY==1, else to RWAIT.
REQ-023 SHALL, in RWAIT, decrement the counter each enabled cycle and go to RESP when the counter reaches 0, giving an accept-edge-to-SResp latency of exactly RD_LATENCY enabled cycles.
REQ-024 SHALL, in RESP, present registered SResp=DVA with SData=stored word for an in-range read, or SResp=ERR with SData=0 for an out-of-range read, for exactly one enabled cycle, then return to IDLE.
REQ-025 SHALL drive SResp=NULL and SData=0 in every state other than RESP.
REQ-026 SHALL, when a write to the same word is accepted while a read is in RWAIT, return the value stored at the RD accept edge.
REQ-027 SHALL, while EnableClk=0, hold state, counter, storage, SResp, SData and wr_err, and force SCmdAccept=0 and SDataAccept=0.
REQ-028 SHALL treat MCmd codes other than 001 and 010 as IDLE: no accept, no state change.
REQ-029 SHALL produce the FAIL response code (10) in no case; the code is reserved.

Reset
REQ-030 SHALL, while reset=0, force state IDLE, counter 0, SResp 00, SData 0, wr_err 0 and all storage words to 0, asynchronously.
REQ-031 SHALL, on reset asserted mid-read, discard the pending response so that no DVA or ERR appears after reset release.
REQ-032 SHALL allow the first command to be accepted on the first enabled edge after reset deasserts.

Structure
REQ-033 SHALL take `MADDR_WIDTH, `MDATA_WIDTH, `SDATA_WIDTH and the MCmd/SResp encodings from shared const.vh, the same header the OCP master uses.
REQ-034 SHALL place storage in one sub-module, ocp_slave_mem (DEPTH x `MDATA_WIDTH, one synchronous write port, one asynchronous read port, async active-low clear); the FSM, counter and response registers stay in ocp_slave_fsm.

Verification
REQ-035 SHALL cover write then read: WR MAddr=3, MData=0xA5, MDataValid=1 -> SCmdAccept=1 in the same cycle; then RD MAddr=3 -> SResp=01 and SData=0xA5 exactly 2 cycles after accept, SResp=00 one cycle later.
REQ-036 SHALL cover the data handshake: WR MAddr=1 held with MDataValid=0 for 3 cycles -> SCmdAccept=0 and word 1 stays 0; MDataValid=1 -> accepted that cycle.
REQ-037 SHALL cover out-of-range access: WR MAddr=DEPTH -> wr_err pulse, storage unchanged; RD MAddr=DEPTH+5 -> SResp=11 and SData=0 after RD_LATENCY cycles.
REQ-038 SHALL cover back-pressure during a read: RD accepted, then RD issued during RWAIT -> SCmdAccept=0 until RESP completes; second RD accepted on the first cycle back in IDLE.
REQ-039 SHALL cover the clock enable: EnableClk=0 for 4 cycles during RWAIT -> response delayed by exactly 4 cycles and SCmdAccept=0 throughout.
REQ-040 SHALL cover reset mid-read: reset=0 one cycle after RD accept -> SResp=00 persists after release, word read back returns 0, and the MCmd=100 code is ignored.
